// File: rtl/fifo_sync_thr_pkg.sv
// Package for fifo_sync_thr: default sizes, the registered flag bundle and
// the sticky error-flag update helper.
//   FIFO_DW / FIFO_AW  default parameter values taken from fifo_defs.vh
//   fifo_flags_t       full / empty / almost_full / almost_empty bundle
//   sticky_next()      next value of a sticky flag with set priority
package fifo_sync_thr_pkg;
`include "fifo_defs.vh"

   localparam int FIFO_DW = `FIFO_DW_DEF;
   localparam int FIFO_AW = `FIFO_AW_DEF;

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
   } fifo_flags_t;

   // A set request in the same cycle as a clear keeps the flag asserted.
   function automatic logic sticky_next(input logic set, input logic cur, input logic clr);
      return set | (cur & ~clr);
   endfunction

endpackage

// File: rtl/fifo_defs.vh
// Shared FIFO defaults for every FIFO variant in the tree.
//   FIFO_DW_DEF     default data width in bits
//   FIFO_AW_DEF     default pointer width in bits
//   FIFO_DEPTH(aw)  number of entries for a pointer width of aw bits
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DW_DEF 8
`define FIFO_AW_DEF 3
`define FIFO_DEPTH(aw) (1 << (aw))

`endif

// File: rtl/fifo_sync_thr_ram.sv
// fifo_sync_thr_ram: DEPTH x DATA_WIDTH storage, no reset on contents.
//   clk    clock
//   we     write enable (synchronous write)
//   waddr  write address
//   wdata  write data
//   raddr  read address (asynchronous read)
//   rdata  word stored at raddr
module fifo_sync_thr_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_thr.sv
// fifo_sync_thr: single-clock FIFO with registered threshold flags, sticky
// overflow/underflow errors and a pop_valid strobe.
// Configuration macro FIFO_FWFT_EN:
//   undefined - registered read, pop_data/pop_valid one cycle after an accepted pop
//   defined   - first-word-fall-through, head word shown while not empty
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_data       write request and data
//   pop, pop_data         read request and data
//   pop_valid             pop_data valid
//   th_af, th_ae          almost_full / almost_empty thresholds
//   err_clr               clears overflow and underflow
//   count                 occupancy 0..DEPTH
//   full, empty           occupancy at DEPTH / zero
//   almost_full           count >= th_af
//   almost_empty          count <= th_ae
//   overflow, underflow   sticky error flags
// Handshake: a push is taken only when full is low and a pop only when empty
// is low, both judged on the flags present before the clock edge; a rejected
// request changes nothing except the matching error flag.
module fifo_sync_thr
   import fifo_sync_thr_pkg::*;
#(
   parameter int DATA_WIDTH = FIFO_DW,
   parameter int ADDR_WIDTH = FIFO_AW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  pop_valid,
   input  logic [ADDR_WIDTH:0]   th_af,
   input  logic [ADDR_WIDTH:0]   th_ae,
   input  logic                  err_clr,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(`FIFO_DEPTH(ADDR_WIDTH));

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_r;
   logic [ADDR_WIDTH:0]   count_nxt;
   fifo_flags_t           flags_r;
   fifo_flags_t           flags_nxt;
   logic                  overflow_r;
   logic                  underflow_r;
   logic                  push_acc;
   logic                  pop_acc;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign push_acc = push & ~flags_r.full;
   assign pop_acc  = pop  & ~flags_r.empty;

   always_comb begin
      count_nxt = count_r + {{ADDR_WIDTH{1'b0}}, push_acc} - {{ADDR_WIDTH{1'b0}}, pop_acc};
   end

   // Flags come from count_nxt so they change on the same edge as count.
   always_comb begin
      flags_nxt              = '0;
      flags_nxt.full         = (count_nxt == DEPTH_C);
      flags_nxt.empty        = (count_nxt == '0);
      flags_nxt.almost_full  = (count_nxt >= th_af);
      flags_nxt.almost_empty = (count_nxt <= th_ae);
   end

   fifo_sync_thr_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (push_acc),
      .waddr (wr_ptr),
      .wdata (push_data),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   // Pointers wrap DEPTH-1 -> 0 through natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_r     <= '0;
         flags_r     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count_r     <= count_nxt;
         flags_r     <= flags_nxt;
         overflow_r  <= sticky_next(push & flags_r.full, overflow_r, err_clr);
         underflow_r <= sticky_next(pop & flags_r.empty, underflow_r, err_clr);
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word is presented directly; gated to zero while empty so the
   // output matches the reset value whenever nothing is stored.
   assign pop_data  = flags_r.empty ? '0 : ram_rdata;
   assign pop_valid = ~flags_r.empty;
`else
   logic [DATA_WIDTH-1:0] pop_data_r;
   logic                  pop_valid_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pop_data_r  <= '0;
         pop_valid_r <= 1'b0;
      end else begin
         pop_valid_r <= pop_acc;
         if (pop_acc) begin
            pop_data_r <= ram_rdata;
         end
      end
   end

   assign pop_data  = pop_data_r;
   assign pop_valid = pop_valid_r;
`endif

   assign count        = count_r;
   assign full         = flags_r.full;
   assign empty        = flags_r.empty;
   assign almost_full  = flags_r.almost_full;
   assign almost_empty = flags_r.almost_empty;
   assign overflow     = overflow_r;
   assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync_thr.sv
// Bench for fifo_sync_thr (DATA_WIDTH=8, ADDR_WIDTH=3). Works in both read
// modes; FIFO_FWFT_EN selects which read timing is expected.
module tb_fifo_sync_thr;
   logic       clk = 1'b0;
   logic       rst;
   logic       push;
   logic [7:0] push_data;
   logic       pop;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic [3:0] th_af;
   logic [3:0] th_ae;
   logic       err_clr;
   logic [3:0] count;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;

   int checks = 0;
   int errors = 0;
   int mc = 0;                 // expected occupancy
   logic [7:0] exp_q[$];       // expected read order

   typedef struct {
      logic       p;
      logic [7:0] d;
      logic       q;
      logic       c;
      logic [3:0] cnt;
      logic       full, empty, af, ae, ovf, unf;
   } vec_t;
   vec_t vecs[$];

   fifo_sync_thr #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .clk (clk), .rst (rst), .push (push), .push_data (push_data),
      .pop (pop), .pop_data (pop_data), .pop_valid (pop_valid),
      .th_af (th_af), .th_ae (th_ae), .err_clr (err_clr), .count (count),
      .full (full), .empty (empty), .almost_full (almost_full),
      .almost_empty (almost_empty), .overflow (overflow), .underflow (underflow)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic p, input logic [7:0] d, input logic q, input logic c,
                      input logic [3:0] cnt, input logic f, input logic e,
                      input logic af, input logic ae, input logic ovf, input logic unf);
      vec_t v;
      v.p = p; v.d = d; v.q = q; v.c = c; v.cnt = cnt;
      v.full = f; v.empty = e; v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endtask

   // One clock cycle of stimulus; read data is checked against exp_q.
   task automatic cycle(input logic p, input logic [7:0] d, input logic q, input logic c);
      logic       pa, qa;
      logic [7:0] exp_d;
      pa = p && (mc < 8);
      qa = q && (mc > 0);
      exp_d = 8'h00;
      push = p; push_data = d; pop = q; err_clr = c;
      if (qa) exp_d = exp_q.pop_front();
      if (pa) exp_q.push_back(d);
`ifdef FIFO_FWFT_EN
      #1;
      chk("fwft pop_valid", {31'd0, pop_valid}, {31'd0, (mc > 0)});
      if (mc > 0) begin
         if (qa) chk("fwft pop_data", {24'd0, pop_data}, {24'd0, exp_d});
      end else begin
         chk("fwft pop_data empty", {24'd0, pop_data}, 32'd0);
      end
`endif
      @(posedge clk); #1;
      mc = mc + (pa ? 1 : 0) - (qa ? 1 : 0);
`ifndef FIFO_FWFT_EN
      chk("pop_valid", {31'd0, pop_valid}, {31'd0, qa});
      if (qa) chk("pop_data", {24'd0, pop_data}, {24'd0, exp_d});
`endif
      push = 1'b0; pop = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; push_data = 8'h00; pop = 1'b0; err_clr = 1'b0;
      th_af = 4'd6; th_ae = 4'd2;

      // reset state
      #3;
      chk("rst count", {28'd0, count}, 32'd0);
      chk("rst empty", {31'd0, empty}, 32'd1);
      chk("rst full", {31'd0, full}, 32'd0);
      chk("rst almost_empty", {31'd0, almost_empty}, 32'd1);
      chk("rst almost_full", {31'd0, almost_full}, 32'd0);
      chk("rst pop_data", {24'd0, pop_data}, 32'd0);
      chk("rst pop_valid", {31'd0, pop_valid}, 32'd0);
      chk("rst overflow", {31'd0, overflow}, 32'd0);
      chk("rst underflow", {31'd0, underflow}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // fill:      p   d      q  c  cnt f  e  af ae ov un
      add(1, 8'h01, 0, 0, 4'd1, 0, 0, 0, 1, 0, 0);
      add(1, 8'h02, 0, 0, 4'd2, 0, 0, 0, 1, 0, 0);
      add(1, 8'h03, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0);
      add(1, 8'h04, 0, 0, 4'd4, 0, 0, 0, 0, 0, 0);
      add(1, 8'h05, 0, 0, 4'd5, 0, 0, 0, 0, 0, 0);
      add(1, 8'h06, 0, 0, 4'd6, 0, 0, 1, 0, 0, 0);
      add(1, 8'h07, 0, 0, 4'd7, 0, 0, 1, 0, 0, 0);
      add(1, 8'h08, 0, 0, 4'd8, 1, 0, 1, 0, 0, 0);
      add(1, 8'h09, 0, 0, 4'd8, 1, 0, 1, 0, 1, 0);
      // drain
      add(0, 8'h00, 1, 0, 4'd7, 0, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 0, 4'd6, 0, 0, 1, 0, 1, 0);
      add(0, 8'h00, 1, 0, 4'd5, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 4'd4, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 4'd3, 0, 0, 0, 0, 1, 0);
      add(0, 8'h00, 1, 0, 4'd2, 0, 0, 0, 1, 1, 0);
      add(0, 8'h00, 1, 0, 4'd1, 0, 0, 0, 1, 1, 0);
      add(0, 8'h00, 1, 0, 4'd0, 0, 1, 0, 1, 1, 0);
      add(0, 8'h00, 1, 0, 4'd0, 0, 1, 0, 1, 1, 1);
      add(0, 8'h00, 0, 1, 4'd0, 0, 1, 0, 1, 0, 0);
      // simultaneous on empty, then at count 4, then on full
      add(1, 8'h10, 1, 0, 4'd1, 0, 0, 0, 1, 0, 1);
      add(0, 8'h00, 0, 1, 4'd1, 0, 0, 0, 1, 0, 0);
      add(1, 8'h11, 0, 0, 4'd2, 0, 0, 0, 1, 0, 0);
      add(1, 8'h12, 0, 0, 4'd3, 0, 0, 0, 0, 0, 0);
      add(1, 8'h13, 0, 0, 4'd4, 0, 0, 0, 0, 0, 0);
      add(1, 8'h14, 1, 0, 4'd4, 0, 0, 0, 0, 0, 0);
      add(1, 8'h15, 1, 0, 4'd4, 0, 0, 0, 0, 0, 0);
      add(1, 8'h16, 0, 0, 4'd5, 0, 0, 0, 0, 0, 0);
      add(1, 8'h17, 0, 0, 4'd6, 0, 0, 1, 0, 0, 0);
      add(1, 8'h18, 0, 0, 4'd7, 0, 0, 1, 0, 0, 0);
      add(1, 8'h19, 0, 0, 4'd8, 1, 0, 1, 0, 0, 0);
      add(1, 8'h20, 1, 0, 4'd7, 0, 0, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 4'd7, 0, 0, 1, 0, 0, 0);
      add(0, 8'h00, 1, 0, 4'd6, 0, 0, 1, 0, 0, 0);
      add(0, 8'h00, 1, 0, 4'd5, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].p, vecs[i].d, vecs[i].q, vecs[i].c);
         chk($sformatf("v%0d count", i), {28'd0, count}, {28'd0, vecs[i].cnt});
         chk($sformatf("v%0d full", i), {31'd0, full}, {31'd0, vecs[i].full});
         chk($sformatf("v%0d empty", i), {31'd0, empty}, {31'd0, vecs[i].empty});
         chk($sformatf("v%0d almost_full", i), {31'd0, almost_full}, {31'd0, vecs[i].af});
         chk($sformatf("v%0d almost_empty", i), {31'd0, almost_empty}, {31'd0, vecs[i].ae});
         chk($sformatf("v%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
         chk($sformatf("v%0d underflow", i), {31'd0, underflow}, {31'd0, vecs[i].unf});
      end

      // threshold change at count 5: visible only after the next edge
      th_af = 4'd5;
      #1;
      chk("th_af change before edge", {31'd0, almost_full}, 32'd0);
      cycle(0, 8'h00, 0, 0);
      chk("th_af change after edge", {31'd0, almost_full}, 32'd1);
      th_af = 4'd0; th_ae = 4'd8;
      cycle(0, 8'h00, 0, 0);
      chk("th_af zero", {31'd0, almost_full}, 32'd1);
      chk("th_ae depth", {31'd0, almost_empty}, 32'd1);
      th_af = 4'd6; th_ae = 4'd2;
      cycle(0, 8'h00, 0, 0);
      chk("th restored af", {31'd0, almost_full}, 32'd0);
      chk("th restored ae", {31'd0, almost_empty}, 32'd0);

      // wrap: random traffic with occupancy held inside 1..7
      for (int i = 0; i < 20; i++) begin
         logic p, q;
         p = 1'($urandom_range(0, 1));
         q = 1'($urandom_range(0, 1));
         if (mc <= 1) q = 1'b0;
         if (mc >= 7) p = 1'b0;
         cycle(p, 8'($urandom_range(0, 255)), q, 0);
         chk($sformatf("wrap%0d count", i), {28'd0, count}, mc);
      end

      // drain to empty
      while (mc > 0) cycle(0, 8'h00, 1, 0);
      chk("drained empty", {31'd0, empty}, 32'd1);
      chk("drained underflow", {31'd0, underflow}, 32'd0);

      // asynchronous reset in the middle of a clock period at count 5
      for (int i = 0; i < 5; i++) cycle(1, 8'h60 + 8'(i), 0, 0);
      chk("pre-reset count", {28'd0, count}, 32'd5);
      #2;
      rst = 1'b1;
      #1;
      chk("async rst count", {28'd0, count}, 32'd0);
      chk("async rst empty", {31'd0, empty}, 32'd1);
      chk("async rst pop_valid", {31'd0, pop_valid}, 32'd0);
      chk("async rst pop_data", {24'd0, pop_data}, 32'd0);
      exp_q.delete();
      mc = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      cycle(1, 8'hA5, 0, 0);
      chk("post-reset count", {28'd0, count}, 32'd1);
      cycle(0, 8'h00, 1, 0);
      chk("post-reset empty", {31'd0, empty}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
